// File: rtl/tc_pkg.sv
// Shared types and constants for the tensor-core drain/operand stages.
package tc_pkg;

   // Drain sequencer states
   typedef enum logic [1:0] {
      DRN_IDLE  = 2'd0,
      DRN_ISSUE = 2'd1,
      DRN_DRAIN = 2'd2,
      DRN_DONE  = 2'd3
   } drn_state_t;

   // Default tile geometry and the row-index width derived from it
   localparam int unsigned TC_M      = 16;
   localparam int unsigned TC_DW_POS = $clog2(TC_M);

endpackage

// File: rtl/tc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop in the same cycle frees the slot.
module tc_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wdata,
   input  logic                           pop,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // Storage write; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tc_psum_drain.sv
// Drain stage: requests M psum rows in order, captures returned rows into a
// credit-limited FIFO and streams them out over valid/ready.
module tc_psum_drain
   import tc_pkg::*;
#(
   parameter int unsigned M          = TC_M,
   parameter int unsigned N          = 16,
   parameter int unsigned DW_DATA    = 8,
   parameter int unsigned DW_POS     = TC_DW_POS,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DW_OUT     = N * DW_DATA
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              psum_out_en,
   output logic [DW_POS-1:0] psum_row,
   input  logic              psum_out_valid,
   input  logic [DW_OUT-1:0] psum_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DW_OUT-1:0] m_data,
   output logic [DW_POS-1:0] m_row,
   output logic              m_last,
   output logic              err
);

   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OCW = $clog2(M + 1);
   localparam int unsigned FW  = DW_OUT + DW_POS;
   localparam logic [CW:0]       SUM_MAX  = (CW+1)'(FIFO_DEPTH);
   localparam logic [DW_POS-1:0] ROW_LAST = DW_POS'(M - 1);
   localparam logic [OCW-1:0]    CNT_LAST = OCW'(M - 1);

   drn_state_t        state;
   logic [DW_POS-1:0] issue_row;
   logic [DW_POS-1:0] cap_row;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     fifo_count;
   logic [OCW-1:0]    out_cnt;
   logic              flush;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FW-1:0]     fifo_head;
   logic              credit;
   logic              issue;
   logic              hs;
   logic              ret;
   logic              ret_bad;
   logic              dec;
   logic              push;

   // Returns arriving between a reset and the next start belong to an aborted
   // tile; they are discarded silently rather than flagged as protocol errors.
   assign ret     = psum_out_valid && !flush;
   assign ret_bad = ret && ((inflight == '0) || (fifo_full && !hs));
   assign dec     = ret && (inflight != '0);
   assign push    = ret && !ret_bad;
   assign hs      = !fifo_empty && m_ready;

   assign credit  = ({1'b0, fifo_count} + {1'b0, inflight}) < SUM_MAX;
   assign issue   = (state == DRN_ISSUE) && credit;

   assign m_valid = !fifo_empty;
   assign m_row   = m_valid ? fifo_head[FW-1 -: DW_POS] : '0;
   assign m_data  = m_valid ? fifo_head[DW_OUT-1:0] : '0;
   assign m_last  = m_valid && (m_row == ROW_LAST);

   tc_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({cap_row, psum_out}),
      .pop   (hs),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Sequencer: issue control, credit/capture counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= DRN_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         psum_out_en <= 1'b0;
         psum_row    <= '0;
         issue_row   <= '0;
         cap_row     <= '0;
         inflight    <= '0;
         out_cnt     <= '0;
         err         <= 1'b0;
         flush       <= 1'b1;
      end else begin
         psum_out_en <= 1'b0;
         done        <= 1'b0;
         if (issue && !dec)      inflight <= inflight + 1'b1;
         else if (dec && !issue) inflight <= inflight - 1'b1;
         if (push)    cap_row <= cap_row + 1'b1;
         if (ret_bad) err     <= 1'b1;
         if (hs)      out_cnt <= out_cnt + 1'b1;
         case (state)
            DRN_IDLE: begin
               if (start) begin
                  state     <= DRN_ISSUE;
                  busy      <= 1'b1;
                  issue_row <= '0;
                  cap_row   <= '0;
                  inflight  <= '0;
                  out_cnt   <= '0;
                  flush     <= 1'b0;
               end
            end
            DRN_ISSUE: begin
               if (issue) begin
                  psum_out_en <= 1'b1;
                  psum_row    <= issue_row;
                  issue_row   <= issue_row + 1'b1;
                  if (issue_row == ROW_LAST) state <= DRN_DRAIN;
               end
            end
            DRN_DRAIN: begin
               if (hs && (out_cnt == CNT_LAST)) begin
                  state <= DRN_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            DRN_DONE: begin
               state <= DRN_IDLE;
            end
            default: state <= DRN_IDLE;
         endcase
      end
   end

endmodule
